// File: rtl/fpdiv_sequencer.sv
// fpdiv_sequencer: valid/ready front end for the f32 divide/sqrt core.
// Accepts one operation at a time, holds the operands stable for the core,
// pulses the core clear, counts the core latency and captures the result
// into an output register released under a valid/ready handshake.
// Optional feature macro: FPDIV_SPECIAL_EN resolves IEEE special cases in
// LOAD and bypasses the core run.
module fpdiv_sequencer #(
    parameter int unsigned LATENCY = 12,
    parameter int unsigned CW      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rm,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_n,
    input  logic [31:0] in_d,
    output logic        div_clear,
    output logic        div_rm,
    output logic [1:0]  div_op,
    output logic [31:0] div_n,
    output logic [31:0] div_d,
    input  logic [31:0] div_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);
    localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

    state_t         state;
    state_t         state_next;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           run_last;
    logic           special_hit;
    logic [31:0]    special_value;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign accept    = in_valid & in_ready;
    assign run_last  = (state == S_RUN) && (cnt == CNT_LAST);

`ifdef FPDIV_SPECIAL_EN
    logic n_nan, n_inf, n_zero;
    logic d_nan, d_inf, d_zero;
    logic q_sign;

    assign n_nan  = (div_n[30:23] == 8'hFF) && (div_n[22:0] != '0);
    assign n_inf  = (div_n[30:23] == 8'hFF) && (div_n[22:0] == '0);
    assign n_zero = (div_n[30:0] == '0);
    assign d_nan  = (div_d[30:23] == 8'hFF) && (div_d[22:0] != '0);
    assign d_inf  = (div_d[30:23] == 8'hFF) && (div_d[22:0] == '0);
    assign d_zero = (div_d[30:0] == '0);
    assign q_sign = div_n[31] ^ div_d[31];

    // Classify the registered operands; checks are ordered so NaN-producing
    // cases win over the signed inf/zero results.
    always_comb begin
        special_hit   = 1'b0;
        special_value = '0;
        if (div_op == 2'b00) begin
            if (n_nan || d_nan || (n_zero && d_zero) || (n_inf && d_inf)) begin
                special_hit   = 1'b1;
                special_value = QNAN;
            end else if (d_zero) begin
                special_hit   = 1'b1;
                special_value = {q_sign, 8'hFF, 23'd0};
            end else if (n_zero || d_inf) begin
                special_hit   = 1'b1;
                special_value = {q_sign, 31'd0};
            end
        end else if (div_op == 2'b01) begin
            if (n_nan || (div_n[31] && !n_zero)) begin
                special_hit   = 1'b1;
                special_value = QNAN;
            end else if (n_zero) begin
                special_hit   = 1'b1;
                special_value = div_n;
            end
        end
    end
`else
    assign special_hit   = 1'b0;
    assign special_value = '0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid) state_next = S_LOAD;
            S_LOAD: state_next = special_hit ? S_DONE : S_RUN;
            S_RUN:  if (cnt == CNT_LAST) state_next = S_DONE;
            S_DONE: if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Latency counter: zeroed in LOAD, advances through RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_LOAD) begin
            cnt <= '0;
        end else if (state == S_RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Operand registers and the clear pulse, both driven by acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_clear <= 1'b0;
            div_rm    <= 1'b0;
            div_op    <= '0;
            div_n     <= '0;
            div_d     <= '0;
        end else begin
            div_clear <= accept;
            if (accept) begin
                div_rm <= in_rm;
                div_op <= in_op;
                div_n  <= in_n;
                div_d  <= in_d;
            end
        end
    end

    // Result register: loads only on core capture or the bypass path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_result <= '0;
        end else if (run_last) begin
            out_result <= div_result;
        end else if ((state == S_LOAD) && special_hit) begin
            out_result <= special_value;
        end
    end

endmodule

// File: tb/tb_fpdiv_sequencer.sv
// tb_fpdiv_sequencer: directed bench for fpdiv_sequencer with a fixed-latency
// core model that only presents a valid result on the correct cycle.
module tb_fpdiv_sequencer;

    localparam int unsigned LATENCY = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_rm;
    logic [1:0]  in_op;
    logic [31:0] in_n;
    logic [31:0] in_d;
    logic        div_clear;
    logic        div_rm;
    logic [1:0]  div_op;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] div_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fpdiv_sequencer #(.LATENCY(LATENCY), .CW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rm      (in_rm),
        .in_op      (in_op),
        .in_n       (in_n),
        .in_d       (in_d),
        .div_clear  (div_clear),
        .div_rm     (div_rm),
        .div_op     (div_op),
        .div_n      (div_n),
        .div_d      (div_d),
        .div_result (div_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    // Core model: arithmetic stand-in, valid only LATENCY cycles after clear.
    function automatic logic [31:0] core_fn(input logic [1:0] op, input logic [31:0] n, input logic [31:0] d);
        if (op == 2'b00 && n == 32'h4040_0000 && d == 32'h4000_0000)
            return 32'h3FC0_0000;
        return n ^ {d[15:0], d[31:16]} ^ {30'd0, op};
    endfunction

    logic [7:0] core_cnt = 8'hFF;
    always @(posedge clk) begin
        if (div_clear) core_cnt <= 8'd0;
        else if (core_cnt != 8'hFF) core_cnt <= core_cnt + 8'd1;
    end
    assign div_result = (core_cnt == 8'(LATENCY - 1)) ? core_fn(div_op, div_n, div_d) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after the accept edge; lat = edges until out_valid is seen.
    task automatic wait_result(input string tag, input int lat, input logic [31:0] exp, input bit take);
        @(negedge clk);
        check({tag, " clear_load"}, div_clear, 1);
        check({tag, " busy_load"}, busy, 1);
        check({tag, " valid_load"}, out_valid, 0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) check({tag, " clear_drop"}, div_clear, 0);
            if (k == lat - 1) check({tag, " valid_early"}, out_valid, 0);
            if (k == lat) begin
                check({tag, " valid"}, out_valid, 1);
                check({tag, " result"}, out_result, exp);
            end
        end
        if (take) begin
            @(negedge clk);
            check({tag, " ready_after"}, in_ready, 1);
            check({tag, " valid_after"}, out_valid, 0);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] n, input logic [31:0] d);
        in_valid = 1'b1;
        in_op    = op;
        in_n     = n;
        in_d     = d;
        in_rm    = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] n, input logic [31:0] d,
                          input int lat, input logic [31:0] exp, input bit take);
        check({tag, " ready_idle"}, in_ready, 1);
        drive(op, n, d);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result(tag, lat, exp, take);
    endtask

    logic [31:0] b2b_n [3];
    logic [31:0] b2b_d [3];
    int          acc_time [3];

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_rm     = 1'b0;
        in_op     = 2'b00;
        in_n      = '0;
        in_d      = '0;
        out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst div_clear", div_clear, 0);
        check("rst out_result", out_result, 0);
        check("rst div_n", div_n, 0);
        reset = 1'b0;
        @(negedge clk);

        // 3/2 with the result held in DONE.
        run_op("div3_2", 2'b00, 32'h4040_0000, 32'h4000_0000, LATENCY + 1, 32'h3FC0_0000, 1'b0);
        drive(2'b00, 32'h1111_1111, 32'h2222_2222);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold out_valid", out_valid, 1);
            check("hold out_result", out_result, 32'h3FC0_0000);
            check("hold in_ready", in_ready, 0);
            check("hold div_n", div_n, 32'h4040_0000);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release in_ready", in_ready, 1);
        check("release out_valid", out_valid, 0);
        check("release keep result", out_result, 32'h3FC0_0000);

        // Reset with the counter at 6, then a full-latency recovery.
        check("midrun ready_idle", in_ready, 1);
        drive(2'b01, 32'h4080_0000, 32'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrun out_valid", out_valid, 0);
        check("midrun busy", busy, 0);
        check("midrun out_result", out_result, 0);
        check("midrun div_n", div_n, 0);
        check("midrun in_ready", in_ready, 1);
        drive(2'b00, 32'h4040_0000, 32'h4000_0000);
        @(negedge clk);
        check("rst blocks accept", busy, 0);
        reset = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("recover", LATENCY + 1, 32'h3FC0_0000, 1'b1);

        // Back-to-back with out_ready tied high.
        b2b_n[0] = 32'h4040_0000; b2b_d[0] = 32'h4000_0000;
        b2b_n[1] = 32'h1234_5678; b2b_d[1] = 32'h0F0F_00FF;
        b2b_n[2] = 32'hC120_0000; b2b_d[2] = 32'h3F80_0000;
        begin
            int acount = 0;
            int rcount = 0;
            for (int cyc = 0; cyc < 70; cyc++) begin
                if (out_valid) begin
                    if (rcount < 3)
                        check("b2b result", out_result, core_fn(2'b00, b2b_n[rcount], b2b_d[rcount]));
                    rcount++;
                end
                if (in_ready && acount < 3) begin
                    drive(2'b00, b2b_n[acount], b2b_d[acount]);
                    acc_time[acount] = cyc;
                    acount++;
                end else if (acount >= 3) begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("b2b accepts", acount, 3);
            check("b2b results", rcount, 3);
            check("b2b gap01", acc_time[1] - acc_time[0], 15);
            check("b2b gap12", acc_time[2] - acc_time[1], 15);
        end

`ifdef FPDIV_SPECIAL_EN
        run_op("sp 1/0", 2'b00, 32'h3F80_0000, 32'h0000_0000, 1, 32'h7F80_0000, 1'b1);
        run_op("sp inf/inf", 2'b00, 32'hFF80_0000, 32'hFF80_0000, 1, 32'h7FC0_0000, 1'b1);
        run_op("sp sqrt-4", 2'b01, 32'hC080_0000, 32'h0000_0000, 1, 32'h7FC0_0000, 1'b1);
`else
        run_op("nosp 1/0", 2'b00, 32'h3F80_0000, 32'h0000_0000, LATENCY + 1, 32'h3F80_0000, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
